vote_ballot_collector: RTL and testbench
========================================

Name: vote_ballot_collector

Overview:
- Producer end of the 11-voter ballot interface: collects individual ballots one at a time over a valid/ready handshake and builds the 11-bit vote vector that the majority counter consumes.
- Also presents a registered tally and decision per session.
- Sits between voter-side input logic (buttons, serial link) and the combinational majority vote counter.
- Adds session control, duplicate/illegal-ID rejection, early close and timeout.

Parameters:
- N_VOTERS, 11, number of voters; vector width.
- ID_W, 4, voter ID width; must satisfy 2**ID_W >= N_VOTERS.
- TIMEOUT, 1024, cycles a session stays open before auto-close; must be >= 2.
- CNT_W, 4, tally width; must satisfy 2**CNT_W > N_VOTERS.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; opens a new session from IDLE or DONE.
- close  in  1  pulse; ends the OPEN session early.
- vote_valid  in  1  ballot offered.
- vote_ready  out  1  ballot can be accepted; combinational, equals (state==OPEN).
- vote_id  in  ID_W  voter index, 0..N_VOTERS-1.
- vote_val  in  1  1 = yes, 0 = no.
- votes  out  N_VOTERS  bit i = voter i's ballot; 0 if voter i has not voted.
- voted_mask  out  N_VOTERS  bit i = voter i has voted this session.
- yes_count  out  CNT_W  registered number of yes ballots.
- decision  out  1  registered; 1 iff yes_count > N_VOTERS/2 (integer division; >=6 for 11).
- result_valid  out  1  high while in DONE.
- dup_err  out  1  one-cycle pulse: duplicate ballot rejected.
- id_err  out  1  one-cycle pulse: out-of-range ID rejected.

Behaviour:
- Reset (rst high at a rising edge): state=IDLE; votes, voted_mask, yes_count, decision, result_valid, dup_err, id_err all 0; timeout counter 0. rst has priority over every other input.
- FSM states: IDLE, OPEN, TALLY, DONE.
  - IDLE -> OPEN on start.
  - OPEN -> TALLY on the first of: close, mask full, timeout expiry.
  - TALLY -> DONE unconditionally after 1 cycle.
  - DONE -> OPEN on start.
- Entering OPEN clears votes, voted_mask, yes_count, decision, result_valid, and the timeout counter.
- Handshake: a ballot is accepted at a rising edge when vote_valid && vote_ready.
- On acceptance, with vote_id < N_VOTERS and voted_mask[vote_id]==0: set voted_mask[vote_id] and set votes[vote_id]=vote_val.
- Duplicate rejection: acceptance with voted_mask[vote_id]==1 leaves the first ballot unchanged and pulses dup_err for the next cycle.
- ID rejection: acceptance with vote_id >= N_VOTERS is ignored and pulses id_err for the next cycle. Rejected ballots still complete the handshake and are consumed.
- Mask full: if the accepted ballot fills the mask (all N_VOTERS bits set after the update), the state goes to TALLY at that same edge.
- close with a ballot in the same cycle: the ballot is processed first, then the state goes to TALLY.
- Timeout counter: increments on every OPEN cycle. When the counter equals TIMEOUT-1, the state goes to TALLY at that edge; a ballot in that cycle is still processed.
- TALLY: yes_count = popcount(votes) and decision are registered at the TALLY->DONE edge. Non-voters count as no.
- Latency: a ballot handshake in cycle k that completes the session gives TALLY in cycle k+1 and result_valid=1 in cycle k+2.
- DONE: votes, voted_mask, yes_count and decision hold until the next start. vote_ready=0.
- Ignored inputs:
  - start while in OPEN or TALLY.
  - close outside OPEN.
  - vote_valid outside OPEN (no handshake, no error pulse).
- rst mid-session discards the session and returns to IDLE.

Decomposition:
- Shared package vote_pkg:
  - N_VOTERS_DEF = 11.
  - MAJORITY = N_VOTERS/2 + 1.
  - State enum state_t {IDLE, OPEN, TALLY, DONE}.
  - Error-flag struct {dup, id}.
- Sub-module vote_popcount: parameterised N-bit to CNT_W-bit combinational population count, used in TALLY. It is reusable by the majority counter.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0, vote_ready=0. vote_valid=1 with id 3 in IDLE -> no change, no err.
- Full session: start; ids 0..10 with vals 1,1,1,1,1,1,0,0,0,0,0 on back-to-back cycles -> TALLY the cycle after id 10. The following cycle: result_valid=1, votes=0x03F, yes_count=6, decision=1.
- Duplicate and bad ID: start; id 2 val 1; id 2 val 0 -> dup_err pulse, votes[2] stays 1. id 12 -> id_err pulse, mask unchanged.
- Early close with simultaneous ballot: start; ids 0-4 yes; id 5 yes in the same cycle as close -> voted_mask=0x03F, yes_count=6, decision=1. Next run: ids 0-4 yes only, then close -> yes_count=5, decision=0.
- Timeout: TIMEOUT=16; start, one ballot id 0 yes, then idle -> TALLY exactly 16 cycles after OPEN entry, yes_count=1, decision=0.
- Restart and reset mid-session:
  - start in DONE -> all result outputs cleared next cycle, vote_ready=1.
  - rst asserted after 3 ballots -> IDLE, mask 0.
  - start ignored while OPEN: counter not restarted.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the 11-voter ballot path.
// Used by the ballot collector and the majority counter.
package vote_pkg;

  localparam int N_VOTERS_DEF = 11;
  localparam int MAJORITY     = N_VOTERS_DEF / 2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic dup;
    logic id;
  } err_t;

  // Smallest yes count that wins a strict majority of n voters.
  function automatic int majority_of(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of an N-bit vector.
// Shared between the ballot collector's tally and the majority counter.
module vote_popcount #(
  parameter int N     = 11,
  parameter int CNT_W = 4
) (
  input  logic [N-1:0]     bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/vote_ballot_collector.sv
// Collects one ballot per valid/ready handshake into an N-voter vote vector,
// then registers the tally and majority decision for the session.
module vote_ballot_collector
  import vote_pkg::*;
#(
  parameter int N_VOTERS = N_VOTERS_DEF,
  parameter int ID_W     = 4,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic                vote_valid,
  output logic                vote_ready,
  input  logic [ID_W-1:0]     vote_id,
  input  logic                vote_val,
  output logic [N_VOTERS-1:0] votes,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic [CNT_W-1:0]    yes_count,
  output logic                decision,
  output logic                result_valid,
  output logic                dup_err,
  output logic                id_err,
  output state_t              dbg_state
);

  localparam int CTR_W = $clog2(TIMEOUT);
  localparam int MAJ   = majority_of(N_VOTERS);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TIMEOUT - 1);

  // Handshake: a ballot transfers at a rising edge where vote_valid && vote_ready.
  // vote_ready is high exactly while OPEN; every transferred ballot is consumed,
  // including ones rejected as duplicate or out-of-range.

  state_t                state_q, state_d;
  logic [N_VOTERS-1:0]   votes_q, votes_d;
  logic [N_VOTERS-1:0]   mask_q, mask_d;
  logic [CTR_W-1:0]      ctr_q, ctr_d;
  logic [CNT_W-1:0]      yes_q, yes_d;
  logic                  dec_q, dec_d;
  err_t                  err_q, err_d;

  logic                  accept;
  logic                  id_ok;
  logic [N_VOTERS-1:0]   id_onehot;
  logic [CNT_W-1:0]      pop;

  vote_popcount #(.N(N_VOTERS), .CNT_W(CNT_W)) u_pop (
    .bits_i  (votes_q),
    .count_o (pop)
  );

  assign accept    = vote_valid && (state_q == OPEN);
  assign id_ok     = 32'(vote_id) < N_VOTERS;
  assign id_onehot = id_ok ? (N_VOTERS'(1) << vote_id) : '0;

  always_comb begin
    state_d = state_q;
    votes_d = votes_q;
    mask_d  = mask_q;
    ctr_d   = ctr_q;
    yes_d   = yes_q;
    dec_d   = dec_q;
    err_d   = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = OPEN;
          votes_d = '0;
          mask_d  = '0;
          ctr_d   = '0;
          yes_d   = '0;
          dec_d   = 1'b0;
        end
      end
      OPEN: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (accept) begin
          if (!id_ok) begin
            err_d.id = 1'b1;
          end else if (|(mask_q & id_onehot)) begin
            err_d.dup = 1'b1;
          end else begin
            mask_d  = mask_q | id_onehot;
            votes_d = vote_val ? (votes_q | id_onehot) : (votes_q & ~id_onehot);
          end
        end
        // The ballot of this cycle is folded in before the session can end.
        if (close || (&mask_d) || (ctr_q == CTR_LAST)) begin
          state_d = TALLY;
        end
      end
      TALLY: begin
        yes_d   = pop;
        dec_d   = 32'(pop) >= MAJ;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      votes_q <= '0;
      mask_q  <= '0;
      ctr_q   <= '0;
      yes_q   <= '0;
      dec_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      votes_q <= votes_d;
      mask_q  <= mask_d;
      ctr_q   <= ctr_d;
      yes_q   <= yes_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  assign vote_ready   = (state_q == OPEN);
  assign result_valid = (state_q == DONE);
  assign votes        = votes_q;
  assign voted_mask   = mask_q;
  assign yes_count    = yes_q;
  assign decision     = dec_q;
  assign dup_err      = err_q.dup;
  assign id_err       = err_q.id;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for vote_ballot_collector: a vector table of single-cycle
// steps plus a hand-written timeout / start-while-open sequence.
module tb_vote_ballot_collector;
  import vote_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, close, vote_valid, vote_val;
  logic [3:0]  vote_id;
  logic        vote_ready, decision, result_valid, dup_err, id_err;
  logic [10:0] votes, voted_mask;
  logic [3:0]  yes_count;
  state_t      dbg_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vote_ballot_collector #(
    .N_VOTERS(11), .ID_W(4), .TIMEOUT(16), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .close(close),
    .vote_valid(vote_valid), .vote_ready(vote_ready),
    .vote_id(vote_id), .vote_val(vote_val),
    .votes(votes), .voted_mask(voted_mask), .yes_count(yes_count),
    .decision(decision), .result_valid(result_valid),
    .dup_err(dup_err), .id_err(id_err), .dbg_state(dbg_state)
  );

  // Packed view: {ready, result_valid, dup, id, decision, yes[3:0], mask[10:0], votes[10:0]}
  typedef struct {
    logic        r, s, c, v;
    logic [3:0]  id;
    logic        vl;
    logic [30:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [30:0] pack(input logic er, erv, ed, ei, edc,
                                       input logic [3:0] ey,
                                       input logic [10:0] em, ev);
    return {er, erv, ed, ei, edc, ey, em, ev};
  endfunction

  task automatic add(input logic r, s, c, v, input logic [3:0] id, input logic vl,
                     input logic [10:0] ev, em,
                     input logic er, erv, ed, ei, edc, input logic [3:0] ey);
    vec_t t;
    t.r = r; t.s = s; t.c = c; t.v = v; t.id = id; t.vl = vl;
    t.exp = pack(er, erv, ed, ei, edc, ey, em, ev);
    vq.push_back(t);
  endtask

  function automatic logic [30:0] actual();
    return pack(vote_ready, result_valid, dup_err, id_err, decision, yes_count,
                voted_mask, votes);
  endfunction

  task automatic check(input string name, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; close = 1'b0; vote_valid = 1'b0;
    vote_id = 4'd0; vote_val = 1'b0;
  endtask

  initial begin
    logic [10:0] ev, em;
    int n;
    idle_inputs();

    // Reset, then a ballot offered while IDLE.
    add(1,0,0,0, 0,0, 11'h000, 11'h000, 0,0,0,0,0, 0);
    add(1,0,0,0, 0,0, 11'h000, 11'h000, 0,0,0,0,0, 0);
    add(0,0,0,1, 3,1, 11'h000, 11'h000, 0,0,0,0,0, 0);

    // Full session: voters 0..5 yes, 6..10 no.
    add(0,1,0,0, 0,0, 11'h000, 11'h000, 1,0,0,0,0, 0);
    ev = '0; em = '0;
    for (int i = 0; i < 11; i++) begin
      em[i] = 1'b1;
      ev[i] = (i < 6);
      add(0,0,0,1, 4'(i), (i < 6), ev, em, (i < 10),0,0,0,0, 0);
    end
    add(0,0,0,0, 0,0, 11'h03F, 11'h7FF, 0,1,0,0,1, 6);
    add(0,0,0,0, 0,0, 11'h03F, 11'h7FF, 0,1,0,0,1, 6);

    // Restart from DONE, duplicate, out-of-range ID, close.
    add(0,1,0,0, 0,0, 11'h000, 11'h000, 1,0,0,0,0, 0);
    add(0,0,0,1, 2,1, 11'h004, 11'h004, 1,0,0,0,0, 0);
    add(0,0,0,1, 2,0, 11'h004, 11'h004, 1,0,1,0,0, 0);
    add(0,0,0,0, 0,0, 11'h004, 11'h004, 1,0,0,0,0, 0);
    add(0,0,0,1, 12,1, 11'h004, 11'h004, 1,0,0,1,0, 0);
    add(0,0,1,0, 0,0, 11'h004, 11'h004, 0,0,0,0,0, 0);
    add(0,0,0,0, 0,0, 11'h004, 11'h004, 0,1,0,0,0, 1);
    add(0,0,0,1, 1,1, 11'h004, 11'h004, 0,1,0,0,0, 1);
    add(0,0,1,0, 0,0, 11'h004, 11'h004, 0,1,0,0,0, 1);

    // Early close together with the sixth yes ballot.
    add(0,1,0,0, 0,0, 11'h000, 11'h000, 1,0,0,0,0, 0);
    for (int i = 0; i < 5; i++)
      add(0,0,0,1, 4'(i), 1, 11'((1 << (i + 1)) - 1), 11'((1 << (i + 1)) - 1), 1,0,0,0,0, 0);
    add(0,0,1,1, 5,1, 11'h03F, 11'h03F, 0,0,0,0,0, 0);
    add(0,0,0,0, 0,0, 11'h03F, 11'h03F, 0,1,0,0,1, 6);

    // Early close with only five yes ballots.
    add(0,1,0,0, 0,0, 11'h000, 11'h000, 1,0,0,0,0, 0);
    for (int i = 0; i < 5; i++)
      add(0,0,0,1, 4'(i), 1, 11'((1 << (i + 1)) - 1), 11'((1 << (i + 1)) - 1), 1,0,0,0,0, 0);
    add(0,0,1,0, 0,0, 11'h01F, 11'h01F, 0,0,0,0,0, 0);
    add(0,0,0,0, 0,0, 11'h01F, 11'h01F, 0,1,0,0,0, 5);

    // Reset mid-session discards everything.
    add(0,1,0,0, 0,0, 11'h000, 11'h000, 1,0,0,0,0, 0);
    add(0,0,0,1, 0,1, 11'h001, 11'h001, 1,0,0,0,0, 0);
    add(0,0,0,1, 1,0, 11'h001, 11'h003, 1,0,0,0,0, 0);
    add(0,0,0,1, 2,1, 11'h005, 11'h007, 1,0,0,0,0, 0);
    add(1,0,0,1, 3,1, 11'h000, 11'h000, 0,0,0,0,0, 0);
    add(0,0,0,0, 0,0, 11'h000, 11'h000, 0,0,0,0,0, 0);

    @(negedge clk);
    foreach (vq[k]) begin
      rst = vq[k].r; start = vq[k].s; close = vq[k].c;
      vote_valid = vq[k].v; vote_id = vq[k].id; vote_val = vq[k].vl;
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), {1'b0, actual()}, {1'b0, vq[k].exp});
    end

    // Timeout with a single yes ballot; a start pulse while OPEN is ignored.
    idle_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("open_state", 32'(dbg_state), 32'(OPEN));
    vote_valid = 1'b1; vote_id = 4'd0; vote_val = 1'b1;
    @(posedge clk); #1;
    vote_valid = 1'b0;
    n = 1;
    while (dbg_state != TALLY && n < 40) begin
      start = (n == 5);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("timeout_cycles", 32'(n), 32'd16);
    @(posedge clk); #1;
    check("timeout_result", {1'b0, actual()},
          {1'b0, pack(0,1,0,0,0, 4'd1, 11'h001, 11'h001)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
